// File: rtl/hemaia_csr_regfile.sv
// CSR register bank terminating the HeMAiA hardware-manager CSR req/rsp stream.
// Optional error-access counter enabled by defining HEMAIA_CSR_REGFILE_ERR_CNT_EN.
module hemaia_csr_regfile #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter type csr_req_t = struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  write;
    },
    parameter type csr_rsp_t = struct packed {
        logic [DATA_WIDTH-1:0] data;
    }
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  csr_req_t                       csr_req_i,
    input  logic                           csr_req_valid_i,
    output logic                           csr_req_ready_o,
    output csr_rsp_t                       csr_rsp_o,
    output logic                           csr_rsp_valid_o,
    input  logic                           csr_rsp_ready_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            reg_wr_pulse_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_val_i,
    output logic [15:0]                    err_cnt_o,
    output logic [0:0]                     dbg_state_o
);

    localparam int unsigned BYTE_OFF = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W    = $clog2(NUM_REGS);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $error("hemaia_csr_regfile: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $error("hemaia_csr_regfile: NUM_REGS must be a power of two >= 2");
    end

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RD_RSP = 1'b1
    } state_e;

    state_e                               state_q, state_d;
    logic   [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q;
    logic   [NUM_REGS-1:0]                pulse_q;
    logic   [DATA_WIDTH-1:0]              rsp_q;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  is_ro;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic                  wr_handshake;
    logic                  wr_commit;
    logic                  rd_capture;
    logic                  rd_done;
    logic [NUM_REGS-1:0]   wr_onehot;

    assign word_addr = csr_req_i.addr >> BYTE_OFF;
    assign in_range  = word_addr < ADDR_WIDTH'(NUM_REGS);
    assign idx       = word_addr[IDX_W-1:0];
    assign is_ro     = RO_MASK[idx];

    always_comb begin
        rd_sel = '0;
        if (in_range) begin
            rd_sel = is_ro ? ro_val_i[idx*DATA_WIDTH +: DATA_WIDTH] : reg_q[idx];
        end
    end

    // Handshakes: a request transfers when csr_req_valid_i && csr_req_ready_o.
    // Writes get ready in the same cycle; a read holds ready low until its
    // response is presented, and then req and rsp transfer together in the
    // cycle where csr_req_ready_o, csr_rsp_valid_o and csr_rsp_ready_i are high.
    always_comb begin
        state_d         = state_q;
        csr_req_ready_o = 1'b0;
        csr_rsp_valid_o = 1'b0;
        wr_handshake    = 1'b0;
        rd_capture      = 1'b0;
        rd_done         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (csr_req_valid_i) begin
                    if (csr_req_i.write) begin
                        csr_req_ready_o = 1'b1;
                        wr_handshake    = 1'b1;
                    end else begin
                        rd_capture = 1'b1;
                        state_d    = RD_RSP;
                    end
                end
            end
            RD_RSP: begin
                csr_req_ready_o = 1'b1;
                csr_rsp_valid_o = 1'b1;
                if (csr_rsp_ready_i) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_commit = wr_handshake && in_range && !is_ro;
    assign wr_onehot = wr_commit ? (NUM_REGS'(1) << idx) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            reg_q   <= '0;
            pulse_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= wr_onehot;
            if (wr_commit) begin
                reg_q[idx] <= csr_req_i.data;
            end
            if (rd_capture) begin
                rsp_q <= rd_sel;
            end
        end
    end

    assign reg_o          = reg_q;
    assign reg_wr_pulse_o = pulse_q;
    assign dbg_state_o    = state_q;

    always_comb begin
        csr_rsp_o      = '0;
        csr_rsp_o.data = rsp_q;
    end

`ifdef HEMAIA_CSR_REGFILE_ERR_CNT_EN
    // The out-of-range flag is latched at capture so the count is taken when
    // the read actually completes, not when it is first presented.
    logic        rd_err_q;
    logic        err_inc;
    logic [15:0] err_cnt_q;

    assign err_inc = (wr_handshake && (!in_range || is_ro)) || (rd_done && rd_err_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (rd_capture) begin
                rd_err_q <= !in_range;
            end
            if (err_inc && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hemaia_csr_regfile.sv
// Directed self-checking bench for hemaia_csr_regfile (NUM_REGS=16, 32-bit, reg 15 read-only).
// Error-count expectations follow HEMAIA_CSR_REGFILE_ERR_CNT_EN.
module tb_hemaia_csr_regfile;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        write;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    req_t         req;
    logic         req_valid;
    logic         req_ready;
    rsp_t         rsp;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [511:0] reg_o;
    logic [15:0]  pulse;
    logic [511:0] ro_val;
    logic [15:0]  err_cnt;
    logic [0:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    hemaia_csr_regfile #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (16),
        .RO_MASK   (16'h8000)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .csr_req_i      (req),
        .csr_req_valid_i(req_valid),
        .csr_req_ready_o(req_ready),
        .csr_rsp_o      (rsp),
        .csr_rsp_valid_o(rsp_valid),
        .csr_rsp_ready_i(rsp_ready),
        .reg_o          (reg_o),
        .reg_wr_pulse_o (pulse),
        .ro_val_i       (ro_val),
        .err_cnt_o      (err_cnt),
        .dbg_state_o    (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void err_bump();
`ifdef HEMAIA_CSR_REGFILE_ERR_CNT_EN
        exp_err++;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 after the commit edge with valid low.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int chk_idx,
                            input logic [31:0] chk_val, input logic [15:0] exp_pulse,
                            input bit is_err);
        req.addr  = addr;
        req.data  = data;
        req.write = 1'b1;
        req_valid = 1'b1;
        #1;
        check("wr_ready", req_ready, 1'b1);
        check("wr_no_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req.write = 1'b0;
        if (is_err) err_bump();
        check("wr_pulse", pulse, exp_pulse);
        check("wr_reg", reg_o[chk_idx*32 +: 32], chk_val);
        check("wr_err_cnt", err_cnt, exp_err);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input int hold,
                           input bit is_err);
        exp_q.push_back(exp_data);
        req.addr  = addr;
        req.data  = 32'hDEAD_BEEF;
        req.write = 1'b0;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        #1;
        check("rd_ready_low", req_ready, 1'b0);
        check("rd_valid_low", rsp_valid, 1'b0);
        check("rd_state_idle", dbg_state, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < hold; i++) begin
            check("rd_hold_valid", rsp_valid, 1'b1);
            check("rd_hold_ready", req_ready, 1'b1);
            check("rd_hold_data", rsp.data, exp_q[0]);
            check("rd_hold_err_cnt", err_cnt, exp_err);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("rd_valid", rsp_valid, 1'b1);
        check("rd_ready", req_ready, 1'b1);
        check("rd_data", rsp.data, exp_q.pop_front());
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        if (is_err) err_bump();
        check("rd_back_idle", dbg_state, 1'b0);
        check("rd_valid_drop", rsp_valid, 1'b0);
        check("rd_err_cnt", err_cnt, exp_err);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        ro_val    = '0;
        ro_val[15*32 +: 32] = 32'h0000_1234;
        ro_val[2*32 +: 32]  = 32'hBAD0_0002;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp.data, 32'h0);
        check("rst_reg_o", reg_o[63:0], 64'h0);
        check("rst_pulse", pulse, 16'h0);
        check("rst_err_cnt", err_cnt, 16'h0);
        check("rst_state", dbg_state, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write reg 2, pulse for exactly one cycle, then read it back.
        do_write(32'h08, 32'hA5A5_0001, 2, 32'hA5A5_0001, 16'h0004, 1'b0);
        @(posedge clk);
        #1;
        check("wr_pulse_clear", pulse, 16'h0);
        check("wr_reg_hold", reg_o[2*32 +: 32], 32'hA5A5_0001);
        do_read(32'h08, 32'hA5A5_0001, 0, 1'b0);

        // Read-only reg 15: write discarded and counted, read returns status.
        do_write(32'h3C, 32'h0000_FFFF, 15, 32'h0, 16'h0, 1'b1);
        do_read(32'h3C, 32'h0000_1234, 0, 1'b0);

        // Out-of-range read with backpressure, then out-of-range write.
        do_read(32'h40, 32'h0, 3, 1'b1);
        do_write(32'h40, 32'h0000_0099, 0, 32'h0, 16'h0, 1'b1);

        // Byte offset within the word is ignored.
        do_write(32'h0D, 32'h0000_0033, 3, 32'h0000_0033, 16'h0008, 1'b0);
        do_read(32'h0E, 32'h0000_0033, 0, 1'b0);

        // Read immediately after a write sees the new value.
        do_write(32'h00, 32'h0000_0077, 0, 32'h0000_0077, 16'h0001, 1'b0);
        do_read(32'h00, 32'h0000_0077, 0, 1'b0);

        // Back-to-back writes, one per cycle.
        do_write(32'h04, 32'h0000_0011, 1, 32'h0000_0011, 16'h0002, 1'b0);
        do_write(32'h14, 32'h0000_0055, 5, 32'h0000_0055, 16'h0020, 1'b0);
        check("b2b_first_kept", reg_o[1*32 +: 32], 32'h0000_0011);

        // Reset while a read response is pending.
        req.addr  = 32'h08;
        req.write = 1'b0;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_rsp_valid", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        exp_err = 0;
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_state", dbg_state, 1'b0);
        check("mid_rst_rsp_data", rsp.data, 32'h0);
        check("mid_rst_reg_o_lo", reg_o[255:0], 256'h0);
        check("mid_rst_reg_o_hi", reg_o[511:256], 256'h0);
        check("mid_rst_err_cnt", err_cnt, 16'h0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_read(32'h08, 32'h0, 0, 1'b0);
        do_write(32'h08, 32'h0000_0005, 2, 32'h0000_0005, 16'h0004, 1'b0);
        do_read(32'h08, 32'h0000_0005, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hemaia_csr_regfile.md
Name: hemaia_csr_regfile

Overview:
Memory-mapped CSR register bank that terminates the CSR req/rsp stream produced by the AXI-Lite-to-CSR converter in the HeMAiA hardware manager.
- Holds NUM_REGS software-writable control registers and exposes them to the hardware manager logic.
- Returns hardware status values for registers marked read-only.
- Implements the converter's read contract: a read completes only in a cycle where csr_req_ready_o and csr_rsp_valid_o are both high.

Parameters:
ADDR_WIDTH, 32, CSR byte-address width.
DATA_WIDTH, 32, register width; must be 32 or 64.
NUM_REGS, 16, number of registers; power of two, >= 2.
RO_MASK, '0 (NUM_REGS bits), bit i = 1 makes register i read-only, sourced from ro_val_i.
csr_req_t, logic, request struct {addr, data, write}.
csr_rsp_t, logic, response struct {data}.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
csr_req_i  in  csr_req_t  address, write data, write flag
csr_req_valid_i  in  1  request valid
csr_req_ready_o  out  1  request accepted
csr_rsp_o  out  csr_rsp_t  read data
csr_rsp_valid_o  out  1  read data valid
csr_rsp_ready_i  in  1  read data taken
reg_o  out  NUM_REGS*DATA_WIDTH  current register contents; register i occupies slice i
reg_wr_pulse_o  out  NUM_REGS  one-cycle strobe per register written
ro_val_i  in  NUM_REGS*DATA_WIDTH  status values for RO_MASK registers
err_cnt_o  out  16  error access count (optional feature)

Behaviour:
Reset:
- Reset is asynchronous and active-low on rst_ni.
- All registers, reg_o, reg_wr_pulse_o, csr_rsp_o, csr_rsp_valid_o and err_cnt_o reset to 0.
- FSM resets to IDLE.

Address decode:
- idx = addr >> log2(DATA_WIDTH/8).
- In range when idx < NUM_REGS. Low address bits inside a word are ignored.

FSM, IDLE:
- Write (valid & write): csr_req_ready_o = 1 combinationally. Commit happens on the next clock edge:
  - writable, in-range register: reg[idx] <= data; reg_wr_pulse_o[idx] = 1 for exactly the following cycle, aligned with the reg_o update.
  - read-only or out-of-range target: data discarded, no pulse, handshake still completes.
- Read (valid & !write): csr_req_ready_o = 0. Capture into rsp_q:
  - writable register: reg[idx];
  - read-only register: ro_val_i slice, sampled in this cycle;
  - out of range: 0.
  Then go to RD_RSP.
- No request: stay in IDLE; csr_rsp_valid_o = 0.

FSM, RD_RSP:
- csr_req_valid_i must stay high and the request stable. Behaviour is undefined if it drops.
- csr_rsp_valid_o = 1 and csr_req_ready_o = 1; csr_rsp_o = rsp_q.
- When csr_rsp_ready_i = 1: both handshakes complete, return to IDLE.
- Otherwise hold rsp_q and both outputs unchanged.
- No new request is evaluated in RD_RSP.

Timing and ordering:
- Write latency: 0 wait states; one write per cycle sustained.
- Read latency: response valid 1 cycle after the request is presented; minimum 2 cycles per read.
- Back-to-back: a read following a write in the next cycle returns the newly written value.
- csr_rsp_valid_o is never asserted for writes.
- Reset asserted in RD_RSP: FSM returns to IDLE, csr_rsp_valid_o drops immediately, rsp_q clears.

Optional Feature:
HEMAIA_CSR_REGFILE_ERR_CNT_EN
- Defined:
  - err_cnt_o is a 16-bit saturating counter (sticks at 0xFFFF).
  - Increments by 1 per completed handshake that targets an out-of-range address or writes a read-only register.
  - Increments in the cycle after the handshake; at most +1 per cycle.
  - Register index NUM_REGS-1 is not special.
- Undefined: err_cnt_o tied to 0 and no counter flops exist.

Test Plan:
1. Write 0xA5A5_0001 to addr 0x08 (reg 2) -> ready same cycle; next cycle reg_o[2] = 0xA5A5_0001 and reg_wr_pulse_o = 16'h0004 for 1 cycle.
2. Read addr 0x08 after test 1 with rsp_ready = 1 -> ready low in cycle 0; cycle 1 rsp_valid = ready = 1 with data 0xA5A5_0001; FSM back to IDLE in cycle 2.
3. RO_MASK = 16'h8000, ro_val_i[15] = 0x1234, write 0xFFFF to addr 0x3C -> accepted, reg_o[15] unchanged, no pulse, err_cnt_o = 1 (macro on). Read addr 0x3C -> 0x1234.
4. Read addr 0x40 (out of range) with rsp_ready held 0 for 3 cycles -> rsp_valid/data 0 held stable for 3 cycles; completes on cycle rsp_ready = 1; err_cnt_o increments by 1.
5. Write 0x77 to reg 0, read reg 0 in the immediately next cycle -> read returns 0x77.
6. Assert rst_ni low during RD_RSP -> csr_rsp_valid_o = 0 immediately; all reg_o = 0; the first request after release is handled from IDLE.
